jtopll_mmr: RTL and testbench
=============================

JTOPLL_MMR -- requirements
Module: jtopll_mmr

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port cen, input, 1, clock enable that qualifies slot-counter events.
REQ-004 SHALL have port zero, input, 1, slot-sweep start pulse from the slot counter; meaningful only when cen=1.
REQ-005 SHALL have port wr, input, 1, CPU write strobe; one write per clk cycle in which it is high.
REQ-006 SHALL have port addr, input, 1, CPU port select: 0 = address port, 1 = data port.
REQ-007 SHALL have port din, input, 8, CPU write data.
REQ-008 SHALL have port reg_din, output, 8, data byte presented to the register file.
REQ-009 SHALL have port sel_group, output, 2, target channel group (channel / 3).
REQ-010 SHALL have port sel_sub, output, 3, target subslot (channel mod 3, or patch byte index).
REQ-011 SHALL have ports up_fnumlo, up_fnumhi, up_inst, up_original, up_rhy: outputs, 1 bit each, register-file update strobes.
REQ-012 SHALL have port busy, output, 1, update in progress.
REQ-013 SHALL have port ovf, output, 1, sticky flag set when a data write is dropped.

Function
REQ-014 SHALL latch din into an 8-bit address register on wr=1 and addr=0, in any state.
REQ-015 SHALL decode the latched address on a data write (wr=1, addr=1) as follows:
- 0x00-0x07: up_original, sel_sub=a[2:0]
- 0x0E: up_rhy
- 0x10-0x18: up_fnumlo
- 0x20-0x28: up_fnumhi
- 0x30-0x38: up_inst
- for the channel ranges, ch=a[3:0], sel_group=ch/3, sel_sub=ch%3
REQ-016 SHALL treat every other address (including 0x0F and 0x19-0x1F, 0x29-0x2F, 0x39-0xFF) as a no-op: no strobe, busy unchanged, data discarded.
REQ-017 SHALL run a state machine with states IDLE, WAIT1 and WAIT2; reset state IDLE; busy=1 in WAIT1 and WAIT2.
REQ-018 SHALL, on a valid data write in IDLE, register reg_din, sel_group, sel_sub and exactly one strobe, visible on the cycle after the write, and enter WAIT1.
REQ-019 SHALL move from WAIT1 to WAIT2 on cen=1 and zero=1.
REQ-020 SHALL leave WAIT2 on cen=1 and zero=1, so that each strobe covers at least one complete 18-slot sweep.
REQ-021 SHALL hold strobe, reg_din, sel_group and sel_sub stable throughout WAIT1 and WAIT2.
REQ-022 SHALL, on exit from WAIT2 with the pending buffer empty, clear all strobes and return to IDLE on that cycle.
REQ-023 SHALL have a one-entry pending buffer holding {address, data} for valid writes received while busy=1.
REQ-024 SHALL, on exit from WAIT2 with the pending buffer full, load the pending entry onto the outputs, clear the buffer and enter WAIT1 in that cycle; the strobe may change type without a gap cycle.
REQ-025 SHALL, on a valid data write while busy=1 and the pending buffer full, drop the write and set ovf=1 until reset.
REQ-026 SHALL, when a data write coincides with the WAIT2 exit event, place the new write in the pending buffer first and then apply REQ-024 (i.e. that write is the one issued next).
REQ-027 SHALL ignore zero whenever cen=0; wr is sampled on every clk, independent of cen.
REQ-028 SHALL, on simultaneous zero and a write in IDLE, take the write with the state becoming WAIT1; that zero pulse does not count toward WAIT1 exit.

Reset
REQ-029 SHALL, while rst=1, force:
- state IDLE, address register 0x00, pending buffer empty
- reg_din=0, sel_group=0, sel_sub=0
- all strobes 0, busy=0, ovf=0
REQ-030 SHALL, on rst asserted mid-update, abandon the update: strobes drop on the next edge and the pending entry is discarded.

Verification
REQ-031 SHALL cover: addr 0x15, data 0xA5 in IDLE -> next cycle up_fnumlo=1, sel_group=1, sel_sub=2, reg_din=0xA5, busy=1; strobe held until the second cen&zero, then 0.
REQ-032 SHALL cover: addr 0x03, data 0x7F -> up_original=1, sel_sub=3, sel_group=0; addr 0x0F, data 0x01 -> no strobe, busy stays 0.
REQ-033 SHALL cover: 0x30<-0x42 then, while busy, 0x28<-0x1C -> the up_inst pass ends and up_fnumhi starts in the same cycle with sel_group=2, sel_sub=2, reg_din=0x1C.
REQ-034 SHALL cover: three valid data writes in quick succession while busy -> third dropped, ovf=1; only two updates are issued.
REQ-035 SHALL cover: zero pulses with cen=0 during WAIT1 -> no state change; a data write coincident with the WAIT2 exit is issued next (REQ-026).
REQ-036 SHALL cover: rst asserted while in WAIT2 with an entry pending -> next cycle all outputs 0, busy=0, and no pending update is issued afterwards.

Source files
------------

// File: rtl/jtopll_mmr.sv
// CPU-facing register port for the OPLL core: decodes address/data writes into
// register-file update strobes held for a full slot sweep, with one pending entry.
module jtopll_mmr (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       zero,
  input  logic       wr,
  input  logic       addr,
  input  logic [7:0] din,
  output logic [7:0] reg_din,
  output logic [1:0] sel_group,
  output logic [2:0] sel_sub,
  output logic       up_fnumlo,
  output logic       up_fnumhi,
  output logic       up_inst,
  output logic       up_original,
  output logic       up_rhy,
  output logic       busy,
  output logic       ovf
);

  typedef enum logic [1:0] {IDLE, WAIT1, WAIT2} state_t;

  // stb bit order: {fnumlo, fnumhi, inst, original, rhy}
  typedef struct packed {
    logic       ok;
    logic [4:0] stb;
    logic [1:0] grp;
    logic [2:0] sub;
  } dec_t;

  function automatic dec_t decode(input logic [7:0] a);
    dec_t d;
    d = '0;
    case (a[7:4])
      4'h0: begin
        if (!a[3]) begin
          d.ok  = 1'b1;
          d.stb = 5'b00010;
          d.sub = a[2:0];
        end else if (a[3:0] == 4'hE) begin
          d.ok  = 1'b1;
          d.stb = 5'b00001;
        end
      end
      4'h1, 4'h2, 4'h3: begin
        if (a[3:0] <= 4'd8) begin
          d.ok  = 1'b1;
          d.stb = (a[5:4] == 2'd1) ? 5'b10000 :
                  (a[5:4] == 2'd2) ? 5'b01000 : 5'b00100;
          case (a[3:0])
            4'd0, 4'd1, 4'd2: begin d.grp = 2'd0; d.sub = {1'b0, a[1:0]}; end
            4'd3, 4'd4, 4'd5: begin d.grp = 2'd1; d.sub = 3'(a[3:0] - 4'd3); end
            default:          begin d.grp = 2'd2; d.sub = 3'(a[3:0] - 4'd6); end
          endcase
        end
      end
      default: ;
    endcase
    return d;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [4:0] stb_q, stb_d;
  logic [1:0] grp_q, grp_d;
  logic [2:0] sub_q, sub_d;
  logic       pend_q, pend_d;
  logic [7:0] pend_a_q, pend_a_d;
  logic [7:0] pend_dat_q, pend_dat_d;
  logic       ovf_q, ovf_d;

  dec_t       wdec, pdec, ldec;
  logic       vld, ev, ld;
  logic [7:0] ld_data;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    stb_d      = stb_q;
    grp_d      = grp_q;
    sub_d      = sub_q;
    pend_d     = pend_q;
    pend_a_d   = pend_a_q;
    pend_dat_d = pend_dat_q;
    ovf_d      = ovf_q;
    wdec       = decode(addr_q);
    pdec       = decode(pend_a_q);
    vld        = wr & addr & wdec.ok;
    ev         = cen & zero;
    ld         = 1'b0;
    ldec       = wdec;
    ld_data    = din;

    if (wr && !addr) addr_d = din;

    case (state_q)
      IDLE: ld = vld;
      WAIT1, WAIT2: begin
        if (state_q == WAIT2 && ev) begin
          // A write landing on the exit edge passes through the empty buffer straight out
          if (vld && !pend_q) begin
            ld = 1'b1;
          end else if (pend_q) begin
            ld      = pdec.ok;
            ldec    = pdec;
            ld_data = pend_dat_q;
            pend_d  = 1'b0;
            ovf_d   = ovf_q | vld;
          end else begin
            stb_d   = '0;
            state_d = IDLE;
          end
        end else begin
          if (state_q == WAIT1 && ev) state_d = WAIT2;
          if (vld) begin
            if (pend_q) begin
              ovf_d = 1'b1;
            end else begin
              pend_d     = 1'b1;
              pend_a_d   = addr_q;
              pend_dat_d = din;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (ld && ldec.ok) begin
      state_d = WAIT1;
      stb_d   = ldec.stb;
      grp_d   = ldec.grp;
      sub_d   = ldec.sub;
      data_d  = ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      stb_q      <= '0;
      grp_q      <= '0;
      sub_q      <= '0;
      pend_q     <= 1'b0;
      pend_a_q   <= '0;
      pend_dat_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      stb_q      <= stb_d;
      grp_q      <= grp_d;
      sub_q      <= sub_d;
      pend_q     <= pend_d;
      pend_a_q   <= pend_a_d;
      pend_dat_q <= pend_dat_d;
      ovf_q      <= ovf_d;
    end
  end

  assign reg_din     = data_q;
  assign sel_group   = grp_q;
  assign sel_sub     = sub_q;
  assign up_fnumlo   = stb_q[4];
  assign up_fnumhi   = stb_q[3];
  assign up_inst     = stb_q[2];
  assign up_original = stb_q[1];
  assign up_rhy      = stb_q[0];
  assign busy        = (state_q != IDLE);
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_jtopll_mmr.sv
// Scoreboard bench for jtopll_mmr: expected updates are queued as writes are driven
// and compared once the update should be visible.
module tb_jtopll_mmr;

  logic       clk = 1'b0;
  logic       rst, cen, zero, wr, addr;
  logic [7:0] din;
  logic [7:0] reg_din;
  logic [1:0] sel_group;
  logic [2:0] sel_sub;
  logic       up_fnumlo, up_fnumhi, up_inst, up_original, up_rhy, busy, ovf;

  int          total = 0;
  int          bad   = 0;
  logic [18:0] sb_q[$];
  logic [18:0] exp_v, cur;

  jtopll_mmr dut (
    .clk(clk), .rst(rst), .cen(cen), .zero(zero), .wr(wr), .addr(addr), .din(din),
    .reg_din(reg_din), .sel_group(sel_group), .sel_sub(sel_sub),
    .up_fnumlo(up_fnumlo), .up_fnumhi(up_fnumhi), .up_inst(up_inst),
    .up_original(up_original), .up_rhy(up_rhy), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // {fnumlo, fnumhi, inst, original, rhy, group, sub, data, busy}
  function automatic logic [18:0] mk(input logic [4:0] s, input logic [1:0] g,
                                     input logic [2:0] u, input logic [7:0] d, input logic b);
    return {s, g, u, d, b};
  endfunction

  function automatic logic [18:0] obs();
    return {up_fnumlo, up_fnumhi, up_inst, up_original, up_rhy, sel_group, sel_sub, reg_din, busy};
  endfunction

  task automatic cyc(input logic w, input logic a, input logic [7:0] d, input logic c, input logic z);
    wr = w; addr = a; din = d; cen = c; zero = z;
    @(posedge clk);
    #1;
    wr = 1'b0; addr = 1'b0; din = 8'h00; cen = 1'b0; zero = 1'b0;
  endtask

  task automatic sweep();
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic wreg(input logic [7:0] a, input logic [7:0] d);
    cyc(1'b1, 1'b0, a, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    sb_q.push_back(mk(5'b0, 2'd0, 3'd0, 8'h00, 1'b0));
    exp_v = sb_q.pop_front(); cur = obs(); total++;
    if (cur !== exp_v) begin bad++; $display("FAIL reset_outputs: got %h want %h", cur, exp_v); end
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    rst = 1'b0;
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_fnumlo();
    sb_q.push_back(mk(5'b10000, 2'd1, 3'd2, 8'hA5, 1'b1));
    wreg(8'h15, 8'hA5);
    exp_v = sb_q.pop_front(); cur = obs(); total++;
    if (cur !== exp_v) begin bad++; $display("FAIL fnumlo_issue: got %h want %h", cur, exp_v); end
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    sweep();
    cur = obs(); total++;
    if (cur !== exp_v) begin bad++; $display("FAIL fnumlo_hold: got %h want %h", cur, exp_v); end
    sweep();
    cur = obs(); total++;
    if ({cur[18:14], cur[0]} !== 6'b0) begin
      bad++; $display("FAIL fnumlo_release: got %h want strobes/busy 0", cur);
    end
  endtask

  task automatic test_original_noop();
    sb_q.push_back(mk(5'b00010, 2'd0, 3'd3, 8'h7F, 1'b1));
    wreg(8'h03, 8'h7F);
    exp_v = sb_q.pop_front(); cur = obs(); total++;
    if (cur !== exp_v) begin bad++; $display("FAIL original_issue: got %h want %h", cur, exp_v); end
    sweep(); sweep();
    wreg(8'h0F, 8'h01);
    cur = obs(); total++;
    if ({cur[18:14], cur[0]} !== 6'b0) begin bad++; $display("FAIL noop_0f: got %h want strobes/busy 0", cur); end
    wreg(8'h39, 8'h01);
    cur = obs(); total++;
    if ({cur[18:14], cur[0]} !== 6'b0) begin bad++; $display("FAIL noop_39: got %h want strobes/busy 0", cur); end
    sb_q.push_back(mk(5'b00001, 2'd0, 3'd0, 8'h5A, 1'b1));
    wreg(8'h0E, 8'h5A);
    exp_v = sb_q.pop_front(); cur = obs(); total++;
    if (cur !== exp_v) begin bad++; $display("FAIL rhy_issue: got %h want %h", cur, exp_v); end
    sweep(); sweep();
  endtask

  task automatic test_back_to_back();
    sb_q.push_back(mk(5'b00100, 2'd0, 3'd0, 8'h42, 1'b1));
    wreg(8'h30, 8'h42);
    sb_q.push_back(mk(5'b01000, 2'd2, 3'd2, 8'h1C, 1'b1));
    wreg(8'h28, 8'h1C);
    exp_v = sb_q.pop_front(); cur = obs(); total++;
    if (cur !== exp_v) begin bad++; $display("FAIL b2b_first: got %h want %h", cur, exp_v); end
    sweep();
    cur = obs(); total++;
    if (cur !== exp_v) begin bad++; $display("FAIL b2b_first_hold: got %h want %h", cur, exp_v); end
    sweep();
    exp_v = sb_q.pop_front(); cur = obs(); total++;
    if (cur !== exp_v) begin bad++; $display("FAIL b2b_second: got %h want %h", cur, exp_v); end
    sweep(); sweep();
    cur = obs(); total++;
    if ({cur[18:14], cur[0]} !== 6'b0) begin bad++; $display("FAIL b2b_release: got %h want strobes/busy 0", cur); end
  endtask

  task automatic test_overflow();
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_pre: got %b want 0", ovf); end
    sb_q.push_back(mk(5'b10000, 2'd0, 3'd0, 8'h01, 1'b1));
    wreg(8'h10, 8'h01);
    sb_q.push_back(mk(5'b10000, 2'd0, 3'd0, 8'h02, 1'b1));
    cyc(1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", ovf); end
    exp_v = sb_q.pop_front(); cur = obs(); total++;
    if (cur !== exp_v) begin bad++; $display("FAIL ovf_first: got %h want %h", cur, exp_v); end
    sweep(); sweep();
    exp_v = sb_q.pop_front(); cur = obs(); total++;
    if (cur !== exp_v) begin bad++; $display("FAIL ovf_second: got %h want %h", cur, exp_v); end
    sweep(); sweep();
    for (int i = 0; i < 3; i++) begin
      cur = obs(); total++;
      if ({cur[18:14], cur[0]} !== 6'b0) begin bad++; $display("FAIL ovf_no_third: got %h want strobes/busy 0", cur); end
      sweep();
    end
  endtask

  task automatic test_coincident();
    sb_q.push_back(mk(5'b01000, 2'd0, 3'd1, 8'h55, 1'b1));
    wreg(8'h21, 8'h55);
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    sweep();
    exp_v = sb_q.pop_front(); cur = obs(); total++;
    if (cur !== exp_v) begin bad++; $display("FAIL cen0_hold: got %h want %h", cur, exp_v); end
    cyc(1'b1, 1'b0, 8'h36, 1'b0, 1'b0);
    sb_q.push_back(mk(5'b00100, 2'd2, 3'd0, 8'h99, 1'b1));
    cyc(1'b1, 1'b1, 8'h99, 1'b1, 1'b1);
    exp_v = sb_q.pop_front(); cur = obs(); total++;
    if (cur !== exp_v) begin bad++; $display("FAIL exit_write_next: got %h want %h", cur, exp_v); end
    sweep(); sweep();
    cyc(1'b1, 1'b0, 8'h05, 1'b0, 1'b0);
    sb_q.push_back(mk(5'b00010, 2'd0, 3'd5, 8'h3C, 1'b1));
    cyc(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
    sweep();
    exp_v = sb_q.pop_front(); cur = obs(); total++;
    if (cur !== exp_v) begin bad++; $display("FAIL idle_zero_write: got %h want %h", cur, exp_v); end
    sweep();
    cur = obs(); total++;
    if ({cur[18:14], cur[0]} !== 6'b0) begin bad++; $display("FAIL idle_zero_release: got %h want strobes/busy 0", cur); end
  endtask

  task automatic test_reset_mid();
    sb_q.push_back(mk(5'b10000, 2'd0, 3'd2, 8'h11, 1'b1));
    wreg(8'h12, 8'h11);
    cyc(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
    sweep();
    exp_v = sb_q.pop_front(); cur = obs(); total++;
    if (cur !== exp_v) begin bad++; $display("FAIL mid_pre: got %h want %h", cur, exp_v); end
    rst = 1'b1;
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    cur = obs(); total++;
    if (cur !== 19'h0) begin bad++; $display("FAIL mid_reset_outputs: got %h want 00000", cur); end
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL mid_reset_ovf: got %b want 0", ovf); end
    for (int i = 0; i < 3; i++) begin
      sweep();
      cur = obs(); total++;
      if ({cur[18:14], cur[0]} !== 6'b0) begin bad++; $display("FAIL mid_no_pending: got %h want strobes/busy 0", cur); end
    end
  endtask

  initial begin
    rst = 1'b1; cen = 1'b0; zero = 1'b0; wr = 1'b0; addr = 1'b0; din = 8'h00;
    test_reset();
    test_fnumlo();
    test_original_noop();
    test_back_to_back();
    test_overflow();
    test_coincident();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
